// File: rtl/ram_bus_master.sv
// rtl/ram_bus_master.sv - Request-to-RAM bus master for a 16x8 single-port RAM on a shared data bus.
// Optional build macro RAM_MST_TURNAROUND_EN inserts a bus turnaround cycle after every read.
module ram_bus_master (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       mem_cs,
    output logic       mem_wr,
    output logic [3:0] mem_add,
    inout  wire  [7:0] mem_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        TURN    = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       accept;
    logic       ready_nx;
    logic       cs_nx;
    logic       wr_nx;
    logic       drive_nx;
    logic       drive_en;
    logic [7:0] wr_q;

    assign accept   = req_valid && req_ready;
    assign mem_data = drive_en ? wr_q : 8'hzz;

    // Memory-side controls are derived from the next state and registered, so they
    // change exactly on the edge that enters each phase.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = req_wr ? WRITE : RD_ADDR;
            WRITE:   state_nx = IDLE;
            RD_ADDR: state_nx = RD_DATA;
`ifdef RAM_MST_TURNAROUND_EN
            RD_DATA: state_nx = TURN;
`else
            RD_DATA: state_nx = IDLE;
`endif
            TURN:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        ready_nx = (state_nx == IDLE);
        cs_nx    = (state_nx == WRITE) || (state_nx == RD_ADDR) || (state_nx == RD_DATA);
        wr_nx    = (state_nx == WRITE);
        drive_nx = (state_nx == WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            mem_cs    <= 1'b0;
            mem_wr    <= 1'b0;
            drive_en  <= 1'b0;
            mem_add   <= 4'h0;
            wr_q      <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
        end else begin
            state     <= state_nx;
            req_ready <= ready_nx;
            mem_cs    <= cs_nx;
            mem_wr    <= wr_nx;
            drive_en  <= drive_nx;
            rsp_valid <= (state == RD_DATA);
            if (state == RD_DATA) begin
                rsp_rdata <= mem_data;
            end
            if (accept) begin
                mem_add <= req_addr;
                wr_q    <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_bus_master.sv
// tb/tb_ram_bus_master.sv - Self-checking bench for ram_bus_master with a RAM model and transaction scoreboard.
`timescale 1ns/1ps
module tb_ram_bus_master;

`ifdef RAM_MST_TURNAROUND_EN
    localparam int TURN_CYC = 1;
`else
    localparam int TURN_CYC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_wr;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       mem_cs;
    logic       mem_wr;
    logic [3:0] mem_add;
    wire  [7:0] mem_data;

    always #5 clk = ~clk;

    ram_bus_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_cs    (mem_cs),
        .mem_wr    (mem_wr),
        .mem_add   (mem_add),
        .mem_data  (mem_data)
    );

    // RAM drives reads; a keeper drives 0 whenever chip select is low so any stray master drive shows up.
    logic [7:0] ram [16];
    logic [7:0] ram_q;
    logic       ram_oe;
    logic       keep_oe;
    assign ram_q    = ram[mem_add];
    assign ram_oe   = mem_cs && !mem_wr;
    assign keep_oe  = !mem_cs;
    assign mem_data = ram_oe  ? ram_q : 8'hzz;
    assign mem_data = keep_oe ? 8'h00 : 8'hzz;

    always @(posedge clk) begin
        if (mem_cs && mem_wr) ram[mem_add] <= mem_data;
    end

    typedef struct packed {
        logic       cs;
        logic       wr;
        logic       rsp;
        logic [3:0] addr;
        logic [7:0] bus;
        logic [7:0] rdata;
    } cyc_t;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    cyc_t       q[$];
    int         busy;
    bit         up;
    logic [7:0] m_mem [16];
    logic [7:0] last_rd;
    logic [3:0] last_add;
    int         total;
    int         bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: each accepted request expands into its per-cycle bus picture.
    task automatic model_step();
        bit acc;
        if (!rst_n) begin
            q.delete();
            busy     = 0;
            up       = 0;
            last_rd  = 8'h00;
            last_add = 4'h0;
        end else begin
            if (q.size() > 0) begin
                if (q[0].rsp) last_rd = q[0].rdata;
                void'(q.pop_front());
            end
            acc = up && busy == 0 && req_valid;
            if (busy > 0) busy--;
            up = 1;
            if (acc) begin
                last_add = req_addr;
                if (req_wr) begin
                    m_mem[req_addr] = req_wdata;
                    q.push_back('{1'b1, 1'b1, 1'b0, req_addr, req_wdata, 8'h00});
                    busy = 1;
                end else begin
                    q.push_back('{1'b1, 1'b0, 1'b0, req_addr, m_mem[req_addr], 8'h00});
                    q.push_back('{1'b1, 1'b0, 1'b0, req_addr, m_mem[req_addr], 8'h00});
                    q.push_back('{1'b0, 1'b0, 1'b1, req_addr, 8'h00, m_mem[req_addr]});
                    busy = 2 + TURN_CYC;
                end
            end
        end
    endtask

    task automatic monitor();
        cyc_t e;
        if (q.size() > 0) e = q[0];
        else e = '{1'b0, 1'b0, 1'b0, last_add, 8'h00, 8'h00};
        check("cycle",
              {8'h00, req_ready, mem_cs, mem_wr, mem_add, rsp_valid, rsp_rdata, mem_data},
              {8'h00, (up && busy == 0), e.cs, e.wr, e.addr, e.rsp, (e.rsp ? e.rdata : last_rd), e.bus});
    endtask

    task automatic issue(input logic wr, input logic [3:0] a, input logic [7:0] d, output int n);
        n = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(n < 16), 1);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 4'($urandom);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
    endtask

    vec_t tbl [7];
    int   n;

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 8'h00;
        total     = 0;
        bad       = 0;
        tbl[0] = '{1'b1, 4'h3, 8'hA5, 8'h00};
        tbl[1] = '{1'b0, 4'h3, 8'h00, 8'hA5};
        tbl[2] = '{1'b1, 4'h0, 8'h11, 8'h00};
        tbl[3] = '{1'b1, 4'hF, 8'hEE, 8'h00};
        tbl[4] = '{1'b0, 4'h0, 8'h00, 8'h11};
        tbl[5] = '{1'b0, 4'hF, 8'h00, 8'hEE};
        tbl[6] = '{1'b0, 4'h3, 8'h00, 8'hA5};

        fork
            forever begin
                @(posedge clk or negedge rst_n);
                model_step();
            end
            forever begin
                @(negedge clk);
                monitor();
            end
        join_none

        repeat (2) @(negedge clk);
        check("reset_state", {req_ready, rsp_valid, rsp_rdata, mem_cs, mem_wr, mem_add, mem_data},
              {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00});
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", req_ready, 1);

        for (int i = 0; i < 7; i++) begin
            issue(tbl[i].wr, tbl[i].addr, tbl[i].data, n);
            if (tbl[i].wr) begin
                check("wr_strobe", {mem_cs, mem_wr, mem_add, mem_data}, {2'b11, tbl[i].addr, tbl[i].data});
                @(negedge clk);
                check("wr_one_cycle", {mem_cs, mem_wr}, 2'b00);
            end else begin
                check("rd_addr_phase", {mem_cs, mem_wr, mem_add}, {2'b10, tbl[i].addr});
                wait_rsp(n);
                // two negedges after the RD_ADDR sample = third cycle after acceptance
                check("rsp_latency", n, 2);
                check("rsp_rdata", rsp_rdata, tbl[i].exp);
            end
        end

        issue(1'b0, 4'h3, 8'h00, n);
        issue(1'b1, 4'h7, 8'h3C, n);
        check("rd_wr_gap", n, 2 + TURN_CYC);
        check("wr_after_rd", {mem_cs, mem_wr, mem_add, mem_data}, {2'b11, 4'h7, 8'h3C});

        for (int a = 0; a < 16; a++) begin
            issue(1'b1, 4'(a), 8'($urandom), n);
        end
        repeat (400) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 3) != 0);
            req_wr    = 1'($urandom_range(0, 1));
            req_addr  = 4'($urandom);
            req_wdata = 8'($urandom);
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);

        issue(1'b1, 4'h9, 8'h6B, n);
        issue(1'b0, 4'h9, 8'h00, n);
        @(negedge clk);
        check("rd_data_phase", {mem_cs, mem_wr}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("abort_release", {mem_cs, mem_wr, rsp_valid, mem_data}, {1'b0, 1'b0, 1'b0, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_rsp_after_abort", rsp_valid, 0);
        end
        issue(1'b0, 4'h9, 8'h00, n);
        wait_rsp(n);
        check("post_reset_latency", n, 2);
        check("post_reset_rdata", rsp_rdata, 8'h6B);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ram_bus_master.md
RAM_BUS_MASTER -- requirements
Module: ram_bus_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named and listed as below (clock and reset first).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  1  host request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_wr  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  4  target word address (16 words).
REQ-008 req_wdata  input  8  write data.
REQ-009 rsp_valid  output  1  one-cycle pulse: read data valid.
REQ-010 rsp_rdata  output  8  read data, held until the next read completes.
REQ-011 mem_cs  output  1  chip select to the 16x8 single-port RAM.
REQ-012 mem_wr  output  1  1 = write, 0 = read.
REQ-013 mem_add  output  4  RAM address.
REQ-014 mem_data  inout  8  shared bidirectional data bus; the block drives it only while driving a write, otherwise high-Z.

Function
REQ-015 The block SHALL be an FSM with states IDLE, WRITE, RD_ADDR, RD_DATA and TURN.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready at a rising edge.
REQ-017 On acceptance, the block SHALL register req_addr into mem_add and req_wdata into an internal write register, then go to WRITE (req_wr=1) or RD_ADDR (req_wr=0).
REQ-018 WRITE (1 cycle): mem_cs=1, mem_wr=1, bus driven with the write register; next state is IDLE.
REQ-019 RD_ADDR (1 cycle): mem_cs=1, mem_wr=0, bus released; next state is RD_DATA.
REQ-020 RD_DATA (1 cycle): mem_cs=1, mem_wr=0; mem_data SHALL be sampled into rsp_rdata at the closing edge, with rsp_valid=1 for the following cycle.
REQ-021 After RD_DATA, the next state SHALL be TURN if the turnaround option is enabled, else IDLE.
REQ-022 TURN (1 cycle): mem_cs=0, bus released; next state is IDLE.
REQ-023 In IDLE, mem_cs=0, mem_wr=0 and the bus SHALL be high-Z.
REQ-024 All memory-side outputs and the bus drive-enable SHALL be registered, with no combinational path from req_* to mem_*.
REQ-025 Latency:
- Write: mem write strobe in the cycle after acceptance; 2 cycles per write.
- Read: rsp_valid 3 cycles after the acceptance edge; 3 or 4 cycles per read.
REQ-026 Back-to-back requests SHALL be accepted on the first IDLE cycle; req_valid while not ready SHALL be ignored with no side effect.
REQ-027 mem_add SHALL remain stable for the whole WRITE or read sequence; all 16 addresses (0x0 to 0xF) SHALL be reachable, with no wrap logic needed.
REQ-028 The bus drive-enable and mem_wr SHALL never be 1 during RD_ADDR or RD_DATA; the block SHALL never drive the bus while mem_cs && !mem_wr.

Reset
REQ-029 While rst_n=0, asynchronously:
- State = IDLE.
- req_ready=0 during reset, 1 from the first clock after release.
- rsp_valid=0, rsp_rdata=8'h00.
- mem_cs=0, mem_wr=0, mem_add=4'h0.
- Bus high-Z.
REQ-030 Reset asserted mid-transaction SHALL abort it, with no rsp_valid produced and the bus released immediately.

Configuration
REQ-031 Macro RAM_MST_TURNAROUND_EN:
- Defined: TURN is inserted after every read, guaranteeing one idle bus cycle before any subsequent write drive.
- Undefined: TURN is unreachable and RD_DATA returns directly to IDLE.

Verification
REQ-032 Write 8'hA5 to addr 3, then read addr 3 -> mem_cs/mem_wr=1/1 for exactly one cycle with bus=8'hA5; read returns rsp_rdata=8'hA5 with rsp_valid 3 cycles after acceptance.
REQ-033 Write addr 0=8'h11 and addr 15=8'hEE, read both -> 8'h11 then 8'hEE, mem_add stable throughout each access.
REQ-034 Read then write issued back to back, with the macro defined and undefined -> one TURN cycle with mem_cs=0 only when defined; zero bus contention (no X on mem_data) in both builds.
REQ-035 req_valid held high while busy, with changing req_addr -> only addresses sampled in IDLE cycles are used; no extra mem_cs pulses.
REQ-036 rst_n pulsed low during RD_DATA -> bus high-Z and mem_cs=0 immediately, no rsp_valid; the next read completes normally.
